// File: rtl/msfsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : msfsm_pkg
// Description : Shared constants for the MSFSM transition-barrier scheduler.
//               Contains the state encoding, default sizing constants and a
//               small index-wrap helper.
// Ports       : none (package)
// Config      : MSFSM_TB_RR_EN selects round-robin search in the scheduler
// Revision    : 1.0 - initial release
// ============================================================================
package msfsm_pkg;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;

    localparam int c_N_TRANS_DEFAULT         = 8;
    localparam int c_DEADLOCK_CYCLES_DEFAULT = 16;

    // Successor of idx in a ring of n slots.
    function automatic int next_index(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msfsm_conflict_select.sv
`default_nettype none
// ============================================================================
// Module      : msfsm_conflict_select
// Description : Combinational greedy conflict resolver. Scans transitions in
//               search order start, start+1, ... (mod N_TRANS) and grants each
//               enabled transition that conflicts with none granted earlier
//               in the scan. The grant is maximal and pairwise conflict-free.
// Ports       : trans_en     [N_TRANS]          enabled transitions
//               conflict_mat [N_TRANS*N_TRANS]  bit i*N+j: t_i conflicts t_j
//               start        [PTR_W]            first index of the scan
//               grant        [N_TRANS]          selected transitions
// Revision    : 1.0 - initial release
// ============================================================================
module msfsm_conflict_select #(
    parameter int N_TRANS = 8,
    parameter int PTR_W   = (N_TRANS > 1) ? $clog2(N_TRANS) : 1
) (
    input  logic [N_TRANS-1:0]         trans_en,
    input  logic [N_TRANS*N_TRANS-1:0] conflict_mat,
    input  logic [PTR_W-1:0]           start,
    output logic [N_TRANS-1:0]         grant
);

    always_comb begin
        logic [N_TRANS-1:0] v_grant;
        logic               v_hit;
        v_grant = '0;
        v_hit   = 1'b0;
        // Outer loop walks scan positions; the inner loop picks the single
        // index s occupying position k, so every vector index stays static.
        for (int k = 0; k < N_TRANS; k++) begin
            for (int s = 0; s < N_TRANS; s++) begin
                if (((s - int'(start) + N_TRANS) % N_TRANS) == k) begin
                    v_hit = 1'b0;
                    for (int j = 0; j < N_TRANS; j++) begin
                        // Diagonal is ignored.
                        if (j != s && v_grant[j] && conflict_mat[s*N_TRANS + j]) begin
                            v_hit = 1'b1;
                        end
                    end
                    if (trans_en[s] && !v_hit) begin
                        v_grant[s] = 1'b1;
                    end
                end
            end
        end
        grant = v_grant;
    end

endmodule
`default_nettype wire

// File: rtl/msfsm_tb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : msfsm_tb_scheduler
// Description : Central transition-barrier scheduler for synchronous Mealy
//               MSFSM decompositions. Issues registered one-cycle,
//               conflict-free fire pulses (IDLE -> ISSUE -> SETTLE) and raises
//               a sticky deadlock flag after DEADLOCK_CYCLES idle cycles.
// Ports       : clk          in   system clock, rising edge
//               reset        in   synchronous active-high reset
//               run          in   scheduling enable
//               trans_en     in   [N_TRANS] transitions ready to fire
//               conflict_mat in   [N_TRANS*N_TRANS] symmetric conflict map
//               fire         out  [N_TRANS] one-cycle grant pulses
//               busy         out  high in ISSUE or SETTLE
//               deadlock     out  sticky watchdog flag
// Config      : `define MSFSM_TB_RR_EN for round-robin search start;
//               otherwise fixed priority (index 0 first).
// Revision    : 1.0 - initial release
// ============================================================================
module msfsm_tb_scheduler
    import msfsm_pkg::*;
#(
    parameter int N_TRANS         = c_N_TRANS_DEFAULT,
    parameter int DEADLOCK_CYCLES = c_DEADLOCK_CYCLES_DEFAULT,
    parameter int CNT_W           = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [N_TRANS-1:0]           trans_en,
    input  logic [N_TRANS*N_TRANS-1:0]   conflict_mat,
    output logic [N_TRANS-1:0]           fire,
    output logic                         busy,
    output logic                         deadlock
);

    localparam int PTR_W = (N_TRANS > 1) ? $clog2(N_TRANS) : 1;

    logic [1:0]         r_state;
    logic [N_TRANS-1:0] r_fire;
    logic               r_busy;
    logic               r_deadlock;
    logic [CNT_W-1:0]   r_wd_cnt;
    logic [PTR_W-1:0]   w_start;
    logic [N_TRANS-1:0] w_grant;
    logic               w_launch;

    assign w_launch = (r_state == S_IDLE) && run && (|trans_en);

`ifdef MSFSM_TB_RR_EN
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] w_ptr_next;

    // The first enabled index in search order is always granted, so the next
    // pointer is simply one past the first enabled index found from r_rr_ptr.
    always_comb begin
        logic v_found;
        v_found    = 1'b0;
        w_ptr_next = r_rr_ptr;
        for (int k = 0; k < N_TRANS; k++) begin
            for (int s = 0; s < N_TRANS; s++) begin
                if (((s - int'(r_rr_ptr) + N_TRANS) % N_TRANS) == k &&
                    !v_found && trans_en[s]) begin
                    v_found    = 1'b1;
                    w_ptr_next = PTR_W'(next_index(s, N_TRANS));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= '0;
        end else if (w_launch) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    msfsm_conflict_select #(
        .N_TRANS (N_TRANS),
        .PTR_W   (PTR_W)
    ) u_select (
        .trans_en     (trans_en),
        .conflict_mat (conflict_mat),
        .start        (w_start),
        .grant        (w_grant)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fire     <= '0;
            r_busy     <= 1'b0;
            r_deadlock <= 1'b0;
            r_wd_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_fire     <= w_grant;
                        r_busy     <= 1'b1;
                        r_state    <= S_ISSUE;
                        r_wd_cnt   <= '0;
                        r_deadlock <= 1'b0;
                    end else if (run) begin
                        // Saturating idle counter; flag raises on the edge
                        // where the count reaches DEADLOCK_CYCLES.
                        if (r_wd_cnt != CNT_W'(DEADLOCK_CYCLES)) begin
                            r_wd_cnt <= r_wd_cnt + 1'b1;
                        end
                        if (r_wd_cnt >= CNT_W'(DEADLOCK_CYCLES - 1)) begin
                            r_deadlock <= 1'b1;
                        end
                    end else begin
                        r_wd_cnt <= '0;
                    end
                end
                S_ISSUE: begin
                    r_fire  <= '0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    // trans_en is stale here; the FSMs are still updating.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_fire  <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fire     = r_fire;
    assign busy     = r_busy;
    assign deadlock = r_deadlock;

endmodule
`default_nettype wire

// File: tb/tb_msfsm_tb_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_msfsm_tb_scheduler
// Description : Self-checking bench for msfsm_tb_scheduler. Directed scenarios
//               followed by randomized traffic, compared every cycle against
//               a batch-level reference model of the scheduler rules.
// Config      : honours MSFSM_TB_RR_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msfsm_tb_scheduler;

    localparam int N  = 8;
    localparam int DL = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic [7:0]   trans_en = '0;
    logic [63:0]  conflict_mat = '0;
    logic [7:0]   fire;
    logic         busy;
    logic         deadlock;

    int checks = 0;
    int errors = 0;

    // Reference model state: phase 0 idle, 1 fire visible, 2 settling.
    int         m_phase = 0;
    logic [7:0] m_fire  = '0;
    int         m_idle  = 0;
    logic       m_dl    = 1'b0;
    int         m_ptr   = 0;

    msfsm_tb_scheduler #(
        .N_TRANS         (N),
        .DEADLOCK_CYCLES (DL),
        .CNT_W           (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .trans_en     (trans_en),
        .conflict_mat (conflict_mat),
        .fire         (fire),
        .busy         (busy),
        .deadlock     (deadlock)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input logic [7:0] en, input logic [63:0] cm, input int start);
        logic [7:0] g;
        int s;
        bit ok;
        g = '0;
        for (int k = 0; k < N; k++) begin
            s  = (start + k) % N;
            ok = en[s];
            for (int j = 0; j < N; j++)
                if (j != s && g[j] && cm[s*N + j]) ok = 0;
            if (ok) g[s] = 1'b1;
        end
        return g;
    endfunction

    function automatic int first_en(input logic [7:0] en, input int start);
        for (int k = 0; k < N; k++)
            if (en[(start + k) % N]) return (start + k) % N;
        return start;
    endfunction

    task automatic model_edge();
        int st;
        if (reset) begin
            m_phase = 0; m_fire = '0; m_idle = 0; m_dl = 1'b0; m_ptr = 0;
        end else if (m_phase == 1) begin
            m_phase = 2; m_fire = '0;
        end else if (m_phase == 2) begin
            m_phase = 0;
        end else if (run && trans_en != 8'h00) begin
`ifdef MSFSM_TB_RR_EN
            st = m_ptr;
`else
            st = 0;
`endif
            m_fire  = pick(trans_en, conflict_mat, st);
            m_ptr   = (first_en(trans_en, st) + 1) % N;
            m_phase = 1; m_idle = 0; m_dl = 1'b0;
        end else if (run) begin
            if (m_idle < DL) m_idle++;
            if (m_idle == DL) m_dl = 1'b1;
        end else begin
            m_idle = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock, update the model, then compare away from the edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("fire", fire, m_fire);
        chk("busy", {7'd0, busy}, {7'd0, (m_phase != 0)});
        chk("deadlock", {7'd0, deadlock}, {7'd0, m_dl});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    logic [63:0] cm67;
    logic [63:0] cm_r;
    logic [7:0]  exp_second;

    initial begin
        cm67 = '0;
        cm67[6*N + 7] = 1'b1;
        cm67[7*N + 6] = 1'b1;

        // 1: reset state and deadlock watchdog
        run = 1'b0; trans_en = '0; conflict_mat = '0;
        do_reset();
        chk("rst_fire", fire, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_deadlock", {7'd0, deadlock}, 8'h00);
        run = 1'b1;
        for (int i = 0; i < DL - 1; i++) step();
        chk("dl_before", {7'd0, deadlock}, 8'h00);
        step();
        chk("dl_at_16", {7'd0, deadlock}, 8'h01);
        trans_en = 8'h01;
        step();
        chk("dl_fire", fire, 8'h01);
        chk("dl_clear", {7'd0, deadlock}, 8'h00);
        step(); step();

        // 2/3: t6/t7 conflict, alternation (round-robin) or t6 always
        conflict_mat = cm67; trans_en = 8'hC0;
        do_reset();
`ifdef MSFSM_TB_RR_EN
        exp_second = 8'h80;
`else
        exp_second = 8'h40;
`endif
        step();
        chk("b1_fire", fire, 8'h40);
        chk("b1_busy", {7'd0, busy}, 8'h01);
        step();
        chk("b1_settle_busy", {7'd0, busy}, 8'h01);
        step();
        chk("b1_idle_busy", {7'd0, busy}, 8'h00);
        step();
        chk("b2_fire", fire, exp_second);
        for (int i = 0; i < 12; i++) step();

        // 4: no conflicts, concurrency preserved
        conflict_mat = '0; trans_en = 8'h15;
        step(); step();
        step();
        chk("conc_fire", fire, 8'h15);
        step();
        chk("conc_settle", fire, 8'h00);
        step();

        // 5: reset truncates a pulse in flight
        trans_en = 8'h02;
        step();
        chk("t5_issue", fire, 8'h02);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_fire0", fire, 8'h00);
        chk("t5_busy0", {7'd0, busy}, 8'h00);
        // pointer returns to 0 even after a batch advanced it to 7
        conflict_mat = cm67; trans_en = 8'hC0;
        step();
        chk("t5_pre", fire, 8'h40);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t5_ptr0", fire, 8'h40);
        step(); step();

        // 6: run low blocks batches
        run = 1'b0; trans_en = 8'hFF;
        for (int i = 0; i < 6; i++) step();
        chk("t6_fire0", fire, 8'h00);
        chk("t6_dl0", {7'd0, deadlock}, 8'h00);
        run = 1'b1;
        step();
        chk("t6_fire_nz", {7'd0, |fire}, 8'h01);
        step(); step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) begin
                cm_r = '0;
                for (int a = 0; a < N; a++)
                    for (int b = a; b < N; b++)
                        if ($urandom_range(0, 3) == 0) begin
                            cm_r[a*N + b] = 1'b1;
                            cm_r[b*N + a] = 1'b1;
                        end
                conflict_mat = cm_r;
            end
            reset = ($urandom_range(0, 63) == 0);
            run   = ($urandom_range(0, 7) != 0);
            if ((i % 150) >= 120 || $urandom_range(0, 3) == 0)
                trans_en = 8'h00;
            else
                trans_en = 8'($urandom);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
